// File: rtl/iec_sd_arbiter_pkg.sv
// Shared types and widths for the IEC drive SD-channel arbiter.
// State encoding is fixed so debug captures decode the same across builds.
package iec_sd_arbiter_pkg;

  localparam int LBA_W = 32;
  localparam int SZ_W  = 6;
  localparam int BUF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Width of a drive index; a single drive still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// Bundle of the per-drive SD request signals and the shared host SD channel.
// The arbiter connects through the slave modport; the drive/host side uses master.
interface iec_sd_arbiter_if #(
  parameter int NDRV = 2
);
  import iec_sd_arbiter_pkg::*;

  // Handshake: a drive holds drv_sd_rd/drv_sd_wr as a level until it has seen
  // its ack rise and fall. The host holds sd_ack high for the whole transfer;
  // sd_buff_wr strobes only occur while sd_ack is high. A request is only
  // withdrawn by the drive, never by the host.
  logic [NDRV*LBA_W-1:0] drv_sd_lba;
  logic [NDRV*SZ_W-1:0]  drv_sd_sz;
  logic [NDRV-1:0]       drv_sd_rd;
  logic [NDRV-1:0]       drv_sd_wr;
  logic [NDRV-1:0]       drv_sd_ack;
  logic [NDRV*BUF_W-1:0] drv_sd_buff_din;
  logic [NDRV-1:0]       drv_sd_buff_wr;

  logic [LBA_W-1:0]      sd_lba;
  logic [SZ_W-1:0]       sd_sz;
  logic                  sd_rd;
  logic                  sd_wr;
  logic                  sd_ack;
  logic [BUF_W-1:0]      sd_buff_din;
  logic                  sd_buff_wr;

  logic [NDRV-1:0]       grant;
  logic                  busy;

  modport slave (
    input  drv_sd_lba, drv_sd_sz, drv_sd_rd, drv_sd_wr, drv_sd_buff_din,
    input  sd_ack, sd_buff_wr,
    output drv_sd_ack, drv_sd_buff_wr,
    output sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din,
    output grant, busy
  );

  modport master (
    output drv_sd_lba, drv_sd_sz, drv_sd_rd, drv_sd_wr, drv_sd_buff_din,
    output sd_ack, sd_buff_wr,
    input  drv_sd_ack, drv_sd_buff_wr,
    input  sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din,
    input  grant, busy
  );

endinterface

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping modulo NDRV.
module rr_pick
  import iec_sd_arbiter_pkg::*;
#(
  parameter int NDRV = 2,
  parameter int IW   = idx_w(NDRV)
) (
  input  logic [NDRV-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   win
);

  // Scan from the farthest candidate back to the nearest so the nearest one
  // after 'last' is the final assignment and therefore the winner.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int k = NDRV; k >= 1; k--) begin
      if (req[(int'(last) + k) % NDRV]) begin
        valid = 1'b1;
        win   = IW'((int'(last) + k) % NDRV);
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Shares the single host SD block channel among NDRV IEC drive units with
// round-robin grants; ack and buffer strobes reach only the granted drive.
module iec_sd_arbiter
  import iec_sd_arbiter_pkg::*;
#(
  parameter int NDRV = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  iec_sd_arbiter_if.slave  bus,
  output state_t           dbg_state
);

  localparam int IW = idx_w(NDRV);

  state_t           state_q, state_d;
  logic [NDRV-1:0]  grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    win_q, win_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [SZ_W-1:0]  sz_q, sz_d;
  logic             op_wr_q, op_wr_d;

  logic [NDRV-1:0]  req_v;
  logic             pick_valid;
  logic [IW-1:0]    pick_win;

  assign req_v = bus.drv_sd_rd | bus.drv_sd_wr;

  rr_pick #(
    .NDRV (NDRV),
    .IW   (IW)
  ) u_pick (
    .req   (req_v),
    .last  (last_q),
    .valid (pick_valid),
    .win   (pick_win)
  );

  // last resets to NDRV-1 so drive 0 is the first winner.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NDRV - 1);
      win_q   <= '0;
      lba_q   <= '0;
      sz_q    <= '0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      win_q   <= win_d;
      lba_q   <= lba_d;
      sz_q    <= sz_d;
      op_wr_q <= op_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    win_d   = win_q;
    lba_d   = lba_q;
    sz_d    = sz_q;
    op_wr_d = op_wr_q;
    case (state_q)
      ST_IDLE: begin
        // A high sd_ack here is a leftover host transaction; wait it out.
        if (pick_valid && !bus.sd_ack) begin
          state_d = ST_REQ;
          win_d   = pick_win;
          grant_d = NDRV'(1) << pick_win;
          lba_d   = bus.drv_sd_lba[pick_win * LBA_W +: LBA_W];
          sz_d    = bus.drv_sd_sz[pick_win * SZ_W +: SZ_W];
          op_wr_d = bus.drv_sd_wr[pick_win];
        end
      end
      ST_REQ: begin
        if (bus.sd_ack) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!bus.sd_ack) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold until the owner withdraws so one request is issued only once.
        if (!req_v[win_q]) begin
          state_d = ST_IDLE;
          last_d  = win_q;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sd_rd  = (state_q == ST_REQ) && !op_wr_q;
  assign bus.sd_wr  = (state_q == ST_REQ) &&  op_wr_q;
  assign bus.sd_lba = lba_q;
  assign bus.sd_sz  = sz_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  assign bus.drv_sd_ack     = {NDRV{bus.sd_ack}} & grant_q;
  assign bus.drv_sd_buff_wr = {NDRV{bus.sd_buff_wr}} & grant_q;

  always_comb begin
    bus.sd_buff_din = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (grant_q[i]) bus.sd_buff_din = bus.drv_sd_buff_din[i * BUF_W +: BUF_W];
    end
  end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed bench for iec_sd_arbiter with two drives: grants, routing,
// round-robin order, write priority, sticky requests, reset abort, stray strobes.
module tb_iec_sd_arbiter;
  import iec_sd_arbiter_pkg::*;

  localparam int NDRV = 2;

  logic   clk_sys = 1'b0;
  logic   reset   = 1'b1;
  state_t dbg_state;
  int     checks  = 0;
  int     errors  = 0;

  iec_sd_arbiter_if #(.NDRV(NDRV)) bus ();

  iec_sd_arbiter #(.NDRV(NDRV)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    bus.drv_sd_lba      = '0;
    bus.drv_sd_sz       = '0;
    bus.drv_sd_rd       = '0;
    bus.drv_sd_wr       = '0;
    bus.drv_sd_buff_din = '0;
    bus.sd_ack          = 1'b0;
    bus.sd_buff_wr      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1);
  endtask

  // Host side of one transaction for the drive currently in REQ; the drive
  // withdraws its request in the same cycle the host drops ack.
  task automatic host_cycle(input int drv);
    logic [NDRV-1:0] exp_g;
    exp_g = NDRV'(1) << drv;
    bus.sd_ack = 1'b1;
    #1;
    checks++; if (bus.drv_sd_ack !== exp_g) begin errors++; $display("FAIL hc_ack_route drv%0d got %b exp %b", drv, bus.drv_sd_ack, exp_g); end
    step(1);
    checks++; if (dbg_state !== ST_XFER || bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin errors++; $display("FAIL hc_xfer drv%0d state %0d rd %b wr %b exp state 2 rd 0 wr 0", drv, dbg_state, bus.sd_rd, bus.sd_wr); end
    bus.sd_ack = 1'b0;
    bus.drv_sd_rd[drv] = 1'b0;
    bus.drv_sd_wr[drv] = 1'b0;
    step(1);
    checks++; if (dbg_state !== ST_RELEASE) begin errors++; $display("FAIL hc_release drv%0d state %0d exp 3", drv, dbg_state); end
    step(1);
    checks++; if (dbg_state !== ST_IDLE || bus.grant !== 2'b00) begin errors++; $display("FAIL hc_idle drv%0d state %0d grant %b exp 0 00", drv, dbg_state, bus.grant); end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(2);
    checks++; if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin errors++; $display("FAIL reset_rdwr got rd %b wr %b exp 0 0", bus.sd_rd, bus.sd_wr); end
    checks++; if (bus.sd_lba !== 32'h0 || bus.sd_sz !== 6'h0) begin errors++; $display("FAIL reset_lba got %h sz %h exp 0 0", bus.sd_lba, bus.sd_sz); end
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state grant %b busy %b state %0d exp 00 0 0", bus.grant, bus.busy, dbg_state); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_single_read();
    int cnt1 = 0;
    int bad  = 0;
    bus.drv_sd_lba[63:32] = 32'h0000_0123;
    bus.drv_sd_sz[11:6]   = 6'd1;
    bus.drv_sd_rd         = 2'b10;
    step(1);
    checks++; if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0) begin errors++; $display("FAIL sr_rd got rd %b wr %b exp 1 0", bus.sd_rd, bus.sd_wr); end
    checks++; if (bus.sd_lba !== 32'h123 || bus.sd_sz !== 6'd1) begin errors++; $display("FAIL sr_lba got %h sz %0d exp 123 1", bus.sd_lba, bus.sd_sz); end
    checks++; if (bus.grant !== 2'b10 || bus.busy !== 1'b1) begin errors++; $display("FAIL sr_grant got %b busy %b exp 10 1", bus.grant, bus.busy); end
    bus.drv_sd_lba[63:32] = 32'hDEAD_BEEF;
    step(2);
    bus.sd_ack = 1'b1;
    #1;
    checks++; if (bus.drv_sd_ack !== 2'b10) begin errors++; $display("FAIL sr_ack_route got %b exp 10", bus.drv_sd_ack); end
    step(1);
    checks++; if (bus.sd_rd !== 1'b0 || dbg_state !== ST_XFER) begin errors++; $display("FAIL sr_xfer rd %b state %0d exp 0 2", bus.sd_rd, dbg_state); end
    for (int i = 0; i < 256; i++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      if (bus.drv_sd_buff_wr === 2'b10) cnt1++;
      if (bus.drv_sd_buff_wr[0] !== 1'b0 || bus.drv_sd_ack[0] !== 1'b0) bad++;
      step(1);
      bus.sd_buff_wr = 1'b0;
      #1;
      if (bus.drv_sd_buff_wr !== 2'b00) bad++;
      step(1);
    end
    checks++; if (cnt1 != 256) begin errors++; $display("FAIL sr_strobe_count got %0d exp 256", cnt1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sr_strobe_leak got %0d exp 0", bad); end
    checks++; if (bus.sd_lba !== 32'h123) begin errors++; $display("FAIL sr_lba_hold got %h exp 123", bus.sd_lba); end
    bus.sd_ack    = 1'b0;
    bus.drv_sd_rd = 2'b00;
    step(1);
    checks++; if (dbg_state !== ST_RELEASE) begin errors++; $display("FAIL sr_release state %0d exp 3", dbg_state); end
    step(1);
    checks++; if (dbg_state !== ST_IDLE || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL sr_idle state %0d grant %b busy %b exp 0 00 0", dbg_state, bus.grant, bus.busy); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.drv_sd_rd = 2'b11;
    step(1);
    checks++; if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1) begin errors++; $display("FAIL ct_first got grant %b rd %b exp 01 1", bus.grant, bus.sd_rd); end
    host_cycle(0);
    step(1);
    checks++; if (bus.grant !== 2'b10 || bus.sd_rd !== 1'b1) begin errors++; $display("FAIL ct_second got grant %b rd %b exp 10 1", bus.grant, bus.sd_rd); end
    host_cycle(1);
    bus.drv_sd_rd = 2'b11;
    step(1);
    checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL ct_rr_wrap got grant %b exp 01", bus.grant); end
    host_cycle(0);
    step(1);
    checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL ct_rr_next got grant %b exp 10", bus.grant); end
    host_cycle(1);
  endtask

  task automatic test_write_vs_read();
    bus.drv_sd_buff_din = {8'h3C, 8'hA5};
    bus.drv_sd_rd       = 2'b01;
    bus.drv_sd_wr       = 2'b01;
    step(1);
    checks++; if (bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0 || bus.grant !== 2'b01) begin errors++; $display("FAIL wr_prio wr %b rd %b grant %b exp 1 0 01", bus.sd_wr, bus.sd_rd, bus.grant); end
    bus.sd_ack = 1'b1;
    step(1);
    checks++; if (bus.sd_buff_din !== 8'hA5) begin errors++; $display("FAIL wr_din got %h exp a5", bus.sd_buff_din); end
    bus.drv_sd_buff_din[7:0] = 8'h5A;
    #1;
    checks++; if (bus.sd_buff_din !== 8'h5A) begin errors++; $display("FAIL wr_din_follow got %h exp 5a", bus.sd_buff_din); end
    bus.sd_ack    = 1'b0;
    bus.drv_sd_rd = 2'b00;
    bus.drv_sd_wr = 2'b00;
    step(2);
    checks++; if (dbg_state !== ST_IDLE || bus.sd_buff_din !== 8'h00) begin errors++; $display("FAIL wr_idle_din state %0d din %h exp 0 00", dbg_state, bus.sd_buff_din); end
  endtask

  task automatic test_sticky();
    int bad = 0;
    bus.drv_sd_rd = 2'b01;
    step(1);
    checks++; if (bus.grant !== 2'b01 || bus.sd_rd !== 1'b1) begin errors++; $display("FAIL st_grant grant %b rd %b exp 01 1", bus.grant, bus.sd_rd); end
    bus.sd_ack = 1'b1;
    step(1);
    bus.sd_ack = 1'b0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      if (dbg_state !== ST_RELEASE || bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) bad++;
      step(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL st_hold bad cycles %0d exp 0", bad); end
    bus.drv_sd_rd = 2'b00;
    step(1);
    checks++; if (dbg_state !== ST_IDLE || bus.grant !== 2'b00) begin errors++; $display("FAIL st_idle state %0d grant %b exp 0 00", dbg_state, bus.grant); end
  endtask

  task automatic test_reset_mid_xfer();
    int bad = 0;
    bus.drv_sd_rd = 2'b10;
    step(1);
    bus.sd_ack = 1'b1;
    step(1);
    checks++; if (dbg_state !== ST_XFER || bus.grant !== 2'b10) begin errors++; $display("FAIL rx_pre state %0d grant %b exp 2 10", dbg_state, bus.grant); end
    reset = 1'b1;
    #1;
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.drv_sd_ack !== 2'b00) begin errors++; $display("FAIL rx_async grant %b busy %b ack %b exp 00 0 00", bus.grant, bus.busy, bus.drv_sd_ack); end
    checks++; if (bus.sd_rd !== 1'b0 || bus.sd_lba !== 32'h0 || bus.sd_sz !== 6'h0) begin errors++; $display("FAIL rx_outs rd %b lba %h sz %h exp 0 0 0", bus.sd_rd, bus.sd_lba, bus.sd_sz); end
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (bus.grant !== 2'b00 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rx_block bad cycles %0d exp 0", bad); end
    bus.sd_ack = 1'b0;
    step(1);
    checks++; if (bus.grant !== 2'b10 || bus.sd_rd !== 1'b1 || bus.sd_lba !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rx_regrant grant %b rd %b lba %h exp 10 1 deadbeef", bus.grant, bus.sd_rd, bus.sd_lba); end
    host_cycle(1);
  endtask

  task automatic test_stray();
    bus.sd_ack     = 1'b1;
    bus.sd_buff_wr = 1'b1;
    #1;
    checks++; if (bus.drv_sd_ack !== 2'b00 || bus.drv_sd_buff_wr !== 2'b00) begin errors++; $display("FAIL stray_route ack %b bwr %b exp 00 00", bus.drv_sd_ack, bus.drv_sd_buff_wr); end
    step(1);
    checks++; if (dbg_state !== ST_IDLE || bus.grant !== 2'b00) begin errors++; $display("FAIL stray_state state %0d grant %b exp 0 00", dbg_state, bus.grant); end
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_vs_read();
    test_sticky();
    test_reset_mid_xfer();
    test_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
